stage_release_agent: RTL and testbench

Stage-side endpoint of the reset-sequencing scheme: one instance sits in front of each subsystem (memory, PE array, 3x3 stage, 2x2 stage, display) and consumes that subsystem's active-high hold line from the top-level sequencer. On release it waits a settle interval, issues a one-cycle start pulse, supervises the stage until it reports done or a watchdog expires, and returns sticky done/timeout status toward the sequencer.

---
 rtl/stage_release_agent.sv | 112 +++++++++++
 tb/tb_stage_release_agent.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stage_release_agent.sv
// rtl/stage_release_agent.sv - per-stage reset release, start pulse and watchdog supervisor
module stage_release_agent #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CW             = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold_in,
  input  logic       stage_done,
  output logic       stage_rst,
  output logic       start,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next-state and counter logic; the counter restarts at zero on every state entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (hold_in && (state != ST_HOLD)) begin
      // Sequencer re-hold aborts anything in progress and drops sticky status
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!hold_in) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = '0;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = ST_START;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_START: begin
          // stage_done is deliberately not looked at here
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
        ST_RUN: begin
          // Completion beats the watchdog when both land on the same edge
          if (stage_done) begin
            state_nxt = ST_DONE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = ST_FAULT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_DONE, ST_FAULT: begin
          state_nxt = state;
        end
        default: begin
          // Unused encodings fall back to the safe held state
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register with outputs registered from the next state, so they track the state exactly
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      stage_rst <= 1'b1;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stage_rst <= (state_nxt == ST_HOLD) || (state_nxt == ST_FAULT);
      start     <= (state_nxt == ST_START);
      busy      <= (state_nxt == ST_START) || (state_nxt == ST_RUN);
      done      <= (state_nxt == ST_DONE);
      timeout   <= (state_nxt == ST_FAULT);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_stage_release_agent.sv
// tb/tb_stage_release_agent.sv - directed self-checking bench for stage_release_agent
module tb_stage_release_agent;

  logic       clk;
  logic       rst;
  logic       hold_in;
  logic       stage_done;
  logic       stage_rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [2:0] phase;

  int checks;
  int errors;

  int         start_cnt;
  int         start_first;
  int         busy_cnt;
  int         fault_first;
  int         done_first;
  int         timeout_seen;
  logic       rst_at0;
  logic [2:0] phase_at [0:39];

  stage_release_agent #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(10),
    .CW            (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold_in   (hold_in),
    .stage_done(stage_done),
    .stage_rst (stage_rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_hold();
    hold_in    = 1'b1;
    stage_done = 1'b0;
    tick();
    tick();
  endtask

  // k-th iteration observes outputs after edge E0+k; hold_in is 0 at E0 unless abort_edge is 0
  task automatic run_seq(input int done_edge, input int spur_until, input int abort_edge, input int ncycles);
    start_cnt    = 0;
    start_first  = -1;
    busy_cnt     = 0;
    fault_first  = -1;
    done_first   = -1;
    timeout_seen = 0;
    for (int k = 0; k < ncycles; k++) begin
      hold_in    = (abort_edge >= 0) && (k >= abort_edge);
      stage_done = (k == done_edge) || (k <= spur_until);
      tick();
      phase_at[k] = phase;
      if (k == 0) rst_at0 = stage_rst;
      if (start) begin
        start_cnt++;
        if (start_first < 0) start_first = k;
      end
      if (busy) busy_cnt++;
      if (timeout) begin
        timeout_seen = 1;
        if (fault_first < 0) fault_first = k;
      end
      if (done && done_first < 0) done_first = k;
    end
    stage_done = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    hold_in    = 1'b0;
    stage_done = 1'b0;

    // Reset held low with hold_in released
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_phase", phase, 0);
      check("rst_stage_rst", stage_rst, 1);
      check("rst_others", {start, busy, done, timeout}, 0);
    end
    rst = 1'b1;
    tick();
    check("post_rst_settle", phase, 1);
    check("post_rst_stage_rst", stage_rst, 0);
    go_hold();
    check("hold_phase", phase, 0);

    // Nominal: done sampled at E0+9 (4th RUN cycle)
    run_seq(9, -1, -1, 14);
    check("nom_rst_fall", rst_at0, 0);
    check("nom_settle_phase", phase_at[0], 1);
    check("nom_start_cnt", start_cnt, 1);
    check("nom_start_at", start_first, 4);
    check("nom_run_phase", phase_at[5], 3);
    check("nom_busy_cnt", busy_cnt, 5);
    check("nom_done_at", done_first, 9);
    check("nom_done_held", done, 1);
    check("nom_phase_done", phase, 4);
    check("nom_no_timeout", timeout_seen, 0);
    hold_in = 1'b1;
    tick();
    check("rehold_flags", {done, timeout, busy, start}, 0);
    check("rehold_stage_rst", stage_rst, 1);
    check("rehold_phase", phase, 0);
    go_hold();

    // Watchdog: RUN from E0+5, fault after E0+15
    run_seq(-1, -1, -1, 18);
    check("wd_last_run", phase_at[14], 3);
    check("wd_fault_at", fault_first, 15);
    check("wd_phase", phase, 5);
    check("wd_stage_rst", stage_rst, 1);
    check("wd_timeout", timeout, 1);
    check("wd_no_done", done_first, -1);
    check("wd_busy_cnt", busy_cnt, 11);
    go_hold();

    // Boundary race: done on the cycle where the counter reaches 9
    run_seq(15, -1, -1, 18);
    check("race_done_at", done_first, 15);
    check("race_no_timeout", timeout_seen, 0);
    check("race_phase", phase, 4);
    go_hold();

    // Abort on 2nd SETTLE cycle
    run_seq(-1, -1, 2, 6);
    check("abs_settle", phase_at[1], 1);
    check("abs_hold", phase_at[2], 0);
    check("abs_no_start", start_cnt, 0);
    check("abs_stage_rst", stage_rst, 1);
    check("abs_flags", {done, timeout, busy}, 0);
    go_hold();

    // Abort on 5th RUN cycle
    run_seq(-1, -1, 10, 13);
    check("abr_run", phase_at[9], 3);
    check("abr_hold", phase_at[10], 0);
    check("abr_start_cnt", start_cnt, 1);
    check("abr_busy_cnt", busy_cnt, 6);
    check("abr_flags", {done, timeout, busy}, 0);
    check("abr_stage_rst", stage_rst, 1);
    go_hold();

    // One-cycle low glitch on hold_in
    run_seq(-1, -1, 1, 4);
    check("glitch_settle", phase_at[0], 1);
    check("glitch_hold", phase_at[1], 0);
    check("glitch_no_start", start_cnt, 0);
    go_hold();

    // Spurious done in HOLD, SETTLE and START
    hold_in    = 1'b1;
    stage_done = 1'b1;
    tick();
    check("spur_hold_phase", phase, 0);
    check("spur_hold_done", done, 0);
    run_seq(-1, 5, -1, 18);
    check("spur_start_at", start_first, 4);
    check("spur_run", phase_at[5], 3);
    check("spur_fault_at", fault_first, 15);
    check("spur_no_done", done_first, -1);
    check("spur_phase", phase, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
